// File: rtl/hazard_control_unit_pkg.sv
// Shared encodings for the hazard control unit: EXE operand-forwarding selects and FSM states.
package hazard_control_unit_pkg;

    localparam int REG_W = 4;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    // MEM wins over WB because it holds the younger value of the register.
    function automatic logic [1:0] fwd_sel(
        input logic             fwd_en,
        input logic             mem_we,
        input logic [REG_W-1:0] mem_dst,
        input logic             wb_we,
        input logic [REG_W-1:0] wb_dst,
        input logic [REG_W-1:0] src
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (fwd_en && mem_we && (mem_dst == src)) begin
            sel = FWD_MEM;
        end else if (fwd_en && wb_we && (wb_dst == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {CW{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: bubbles, branch squash, SRAM freeze, operand forwarding and statistics.
//   state    | meaning
//   RUN      | no SRAM access outstanding
//   MEM_WAIT | SRAM access in progress, wait cycles being counted
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int CW       = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forwardEn,
    input  logic [REG_W-1:0] idSrc1,
    input  logic [REG_W-1:0] idSrc2,
    input  logic             idTwoSrc,
    input  logic [REG_W-1:0] exeDestination,
    input  logic             exeWriteBackEn,
    input  logic             exeMemRead,
    input  logic [REG_W-1:0] exeSrc1,
    input  logic [REG_W-1:0] exeSrc2,
    input  logic [REG_W-1:0] memDestination,
    input  logic             memWriteBackEn,
    input  logic             memAccess,
    input  logic [REG_W-1:0] wbDestination,
    input  logic             wbWriteBackEn,
    input  logic             branchTaken,
    input  logic             sramReady,
    input  logic             countClr,
    output logic             freezeFront,
    output logic             flushIFID,
    output logic             flushID2EXE,
    output logic             freezeAll,
    output logic [1:0]       sel1,
    output logic [1:0]       sel2,
    output logic             memTimeout,
    output logic [CW-1:0]    stallCount,
    output logic [CW-1:0]    flushCount,
    output logic [CW-1:0]    waitCount
);

    localparam int WW = $clog2(MAX_WAIT + 1) + 1;
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

    state_e        state_q;
    state_e        state_d;
    logic [WW-1:0] wait_q;
    logic [WW-1:0] wait_d;
    logic          timeout_q;
    logic          timeout_d;

    logic exe_match;
    logic mem_match;
    logic hz;
    logic stall_evt;
    logic flush_evt;

    assign exe_match = exeWriteBackEn &&
                       ((exeDestination == idSrc1) || (idTwoSrc && (exeDestination == idSrc2)));
    assign mem_match = memWriteBackEn &&
                       ((memDestination == idSrc1) || (idTwoSrc && (memDestination == idSrc2)));

    // With forwarding only a load feeding the next instruction cannot be bypassed.
    assign hz = forwardEn ? (exeMemRead && exe_match) : (exe_match || mem_match);

    assign freezeAll = memAccess && !sramReady;

    always_comb begin
        freezeFront = 1'b0;
        flushIFID   = 1'b0;
        flushID2EXE = 1'b0;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        if (freezeAll) begin
            freezeFront = 1'b1;
        end else if (branchTaken) begin
            flushIFID   = 1'b1;
            flushID2EXE = 1'b1;
            flush_evt   = 1'b1;
        end else if (hz) begin
            freezeFront = 1'b1;
            flushID2EXE = 1'b1;
            stall_evt   = 1'b1;
        end
    end

    assign sel1 = fwd_sel(forwardEn, memWriteBackEn, memDestination,
                          wbWriteBackEn, wbDestination, exeSrc1);
    assign sel2 = fwd_sel(forwardEn, memWriteBackEn, memDestination,
                          wbWriteBackEn, wbDestination, exeSrc2);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                if (memAccess && !sramReady) begin
                    state_d = MEM_WAIT;
                    wait_d  = '0;
                end
            end
            MEM_WAIT: begin
                if (wait_q != {WW{1'b1}}) begin
                    wait_d = wait_q + 1'b1;
                end
                if (wait_d >= WAIT_LIMIT) begin
                    timeout_d = 1'b1;
                end
                if (sramReady) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign memTimeout = timeout_q;

    sat_counter #(.CW(CW)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (stall_evt),
        .clr_i   (countClr),
        .count_o (stallCount)
    );

    sat_counter #(.CW(CW)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (flush_evt),
        .clr_i   (countClr),
        .count_o (flushCount)
    );

    sat_counter #(.CW(CW)) u_wait_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (freezeAll),
        .clr_i   (countClr),
        .count_o (waitCount)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: a 16-bit-counter and a 4-bit-counter instance share stimulus
// and are checked every cycle against a behavioural model, plus directed literal expectations.
module tb_hazard_control_unit;
    import hazard_control_unit_pkg::*;

    localparam int MAX_WAIT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       forwardEn = 1'b0;
    logic [3:0] idSrc1 = '0, idSrc2 = '0;
    logic       idTwoSrc = 1'b0;
    logic [3:0] exeDestination = '0;
    logic       exeWriteBackEn = 1'b0, exeMemRead = 1'b0;
    logic [3:0] exeSrc1 = '0, exeSrc2 = '0;
    logic [3:0] memDestination = '0;
    logic       memWriteBackEn = 1'b0, memAccess = 1'b0;
    logic [3:0] wbDestination = '0;
    logic       wbWriteBackEn = 1'b0, branchTaken = 1'b0, sramReady = 1'b1, countClr = 1'b0;

    logic        freezeFront, flushIFID, flushID2EXE, freezeAll, memTimeout;
    logic [1:0]  sel1, sel2;
    logic [15:0] stallCount, flushCount, waitCount;
    logic        freezeFront4, flushIFID4, flushID2EXE4, freezeAll4, memTimeout4;
    logic [1:0]  sel1_4, sel2_4;
    logic [3:0]  stallCount4, flushCount4, waitCount4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.CW(16), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk(clk), .rst(rst), .forwardEn(forwardEn), .idSrc1(idSrc1), .idSrc2(idSrc2),
        .idTwoSrc(idTwoSrc), .exeDestination(exeDestination), .exeWriteBackEn(exeWriteBackEn),
        .exeMemRead(exeMemRead), .exeSrc1(exeSrc1), .exeSrc2(exeSrc2),
        .memDestination(memDestination), .memWriteBackEn(memWriteBackEn), .memAccess(memAccess),
        .wbDestination(wbDestination), .wbWriteBackEn(wbWriteBackEn), .branchTaken(branchTaken),
        .sramReady(sramReady), .countClr(countClr), .freezeFront(freezeFront),
        .flushIFID(flushIFID), .flushID2EXE(flushID2EXE), .freezeAll(freezeAll),
        .sel1(sel1), .sel2(sel2), .memTimeout(memTimeout), .stallCount(stallCount),
        .flushCount(flushCount), .waitCount(waitCount)
    );

    hazard_control_unit #(.CW(4), .MAX_WAIT(MAX_WAIT)) u_dut4 (
        .clk(clk), .rst(rst), .forwardEn(forwardEn), .idSrc1(idSrc1), .idSrc2(idSrc2),
        .idTwoSrc(idTwoSrc), .exeDestination(exeDestination), .exeWriteBackEn(exeWriteBackEn),
        .exeMemRead(exeMemRead), .exeSrc1(exeSrc1), .exeSrc2(exeSrc2),
        .memDestination(memDestination), .memWriteBackEn(memWriteBackEn), .memAccess(memAccess),
        .wbDestination(wbDestination), .wbWriteBackEn(wbWriteBackEn), .branchTaken(branchTaken),
        .sramReady(sramReady), .countClr(countClr), .freezeFront(freezeFront4),
        .flushIFID(flushIFID4), .flushID2EXE(flushID2EXE4), .freezeAll(freezeAll4),
        .sel1(sel1_4), .sel2(sel2_4), .memTimeout(memTimeout4), .stallCount(stallCount4),
        .flushCount(flushCount4), .waitCount(waitCount4)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit reads_reg(input logic [3:0] r);
        return (r == idSrc1) || (idTwoSrc && (r == idSrc2));
    endfunction

    function automatic bit model_hazard();
        bit e, m;
        e = exeWriteBackEn && reads_reg(exeDestination);
        m = memWriteBackEn && reads_reg(memDestination);
        return forwardEn ? (exeMemRead && e) : (e || m);
    endfunction

    // 1 = SRAM freeze, 2 = branch squash, 3 = hazard stall, 0 = nothing
    function automatic int cls();
        if (memAccess && !sramReady) return 1;
        if (branchTaken) return 2;
        if (model_hazard()) return 3;
        return 0;
    endfunction

    function automatic int exp_sel(input logic [3:0] src);
        if (!forwardEn) return 0;
        if (memWriteBackEn && memDestination == src) return 1;
        if (wbWriteBackEn && wbDestination == src) return 2;
        return 0;
    endfunction

    function automatic int sat(input int v, input int cw);
        return (v > (1 << cw) - 1) ? (1 << cw) - 1 : v;
    endfunction

    int m_stall = 0, m_flush = 0, m_wait = 0, m_wcyc = 0;
    bit m_inwait = 1'b0, m_to = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_stall  <= 0;
            m_flush  <= 0;
            m_wait   <= 0;
            m_wcyc   <= 0;
            m_inwait <= 1'b0;
            m_to     <= 1'b0;
        end else begin
            m_stall <= countClr ? 0 : m_stall + ((cls() == 3) ? 1 : 0);
            m_flush <= countClr ? 0 : m_flush + ((cls() == 2) ? 1 : 0);
            m_wait  <= countClr ? 0 : m_wait  + ((cls() == 1) ? 1 : 0);
            if (m_inwait) begin
                m_wcyc <= m_wcyc + 1;
                if (m_wcyc + 1 >= MAX_WAIT) m_to <= 1'b1;
                if (sramReady) m_inwait <= 1'b0;
            end else if (memAccess && !sramReady) begin
                m_inwait <= 1'b1;
                m_wcyc   <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_freezeAll",   int'(freezeAll),   int'(cls() == 1));
        chk("cmp_freezeFront", int'(freezeFront), int'(cls() == 1 || cls() == 3));
        chk("cmp_flushIFID",   int'(flushIFID),   int'(cls() == 2));
        chk("cmp_flushID2EXE", int'(flushID2EXE), int'(cls() == 2 || cls() == 3));
        chk("cmp_sel1",        int'(sel1),        exp_sel(exeSrc1));
        chk("cmp_sel2",        int'(sel2),        exp_sel(exeSrc2));
        chk("cmp_memTimeout",  int'(memTimeout),  int'(m_to));
        chk("cmp_stall16",     int'(stallCount),  sat(m_stall, 16));
        chk("cmp_flush16",     int'(flushCount),  sat(m_flush, 16));
        chk("cmp_wait16",      int'(waitCount),   sat(m_wait, 16));
        chk("cmp_stall4",      int'(stallCount4), sat(m_stall, 4));
        chk("cmp_flush4",      int'(flushCount4), sat(m_flush, 4));
        chk("cmp_wait4",       int'(waitCount4),  sat(m_wait, 4));
        chk("cmp_timeout4",    int'(memTimeout4), int'(m_to));
        chk("cmp_freeze4",     int'(freezeFront4), int'(freezeFront));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        forwardEn = 1'b0; idSrc1 = '0; idSrc2 = '0; idTwoSrc = 1'b0;
        exeDestination = '0; exeWriteBackEn = 1'b0; exeMemRead = 1'b0;
        exeSrc1 = '0; exeSrc2 = '0; memDestination = '0; memWriteBackEn = 1'b0;
        memAccess = 1'b0; wbDestination = '0; wbWriteBackEn = 1'b0;
        branchTaken = 1'b0; sramReady = 1'b1; countClr = 1'b0;
    endtask

    task automatic load_use();
        forwardEn = 1'b1; exeMemRead = 1'b1; exeWriteBackEn = 1'b1;
        exeDestination = 4'd3; idSrc1 = 4'd3;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        forwardEn = 1'b1; memWriteBackEn = 1'b1; memDestination = 4'd7; exeSrc1 = 4'd7;
        #1 chk("rst_sel1_follows", int'(sel1), int'(FWD_MEM));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stallCount", int'(stallCount), 0);
        chk("rst_memTimeout", int'(memTimeout), 0);
        rst = 1'b1;
        idle();
        tick();

        // load-use: one bubble, then MEM forwarding covers it
        load_use();
        #1;
        chk("ldu_freezeFront", int'(freezeFront), 1);
        chk("ldu_flushID2EXE", int'(flushID2EXE), 1);
        chk("ldu_flushIFID",   int'(flushIFID), 0);
        tick();
        idle(); forwardEn = 1'b1; memWriteBackEn = 1'b1; memDestination = 4'd3; exeSrc1 = 4'd3;
        #1;
        chk("ldu_released",   int'(freezeFront), 0);
        chk("ldu_fwd_mem",    int'(sel1), int'(FWD_MEM));
        chk("ldu_stallCount", int'(stallCount), 1);
        tick();

        // no forwarding: MEM dependence on src2 stalls only if src2 is read
        idle(); memWriteBackEn = 1'b1; memDestination = 4'd5; idTwoSrc = 1'b1;
        idSrc2 = 4'd5; idSrc1 = 4'd1; exeSrc1 = 4'd5;
        #1;
        chk("nofwd_stall", int'(freezeFront), 1);
        chk("nofwd_sel1",  int'(sel1), int'(FWD_REG));
        idTwoSrc = 1'b0;
        #1 chk("nofwd_onesrc", int'(freezeFront), 0);
        tick();

        // branch beats a load-use hazard
        idle(); countClr = 1'b1;
        tick();
        countClr = 1'b0;
        chk("clr_stallCount", int'(stallCount), 0);
        load_use(); branchTaken = 1'b1;
        #1;
        chk("br_flushIFID",   int'(flushIFID), 1);
        chk("br_flushID2EXE", int'(flushID2EXE), 1);
        chk("br_freezeFront", int'(freezeFront), 0);
        tick();
        idle();
        #1;
        chk("br_flushCount", int'(flushCount), 1);
        chk("br_stallCount", int'(stallCount), 0);

        // forwarding priority
        forwardEn = 1'b1; memWriteBackEn = 1'b1; wbWriteBackEn = 1'b1;
        memDestination = 4'd7; wbDestination = 4'd7; exeSrc1 = 4'd7; exeSrc2 = 4'd7;
        #1 chk("fwd_mem_first", int'(sel1), 1);
        memWriteBackEn = 1'b0;
        #1;
        chk("fwd_wb_sel1", int'(sel1), 2);
        chk("fwd_wb_sel2", int'(sel2), 2);
        forwardEn = 1'b0;
        #1 chk("fwd_disabled", int'(sel1), 0);
        tick();

        // 4-cycle SRAM wait with a branch held in EXE
        idle(); countClr = 1'b1;
        tick();
        countClr = 1'b0;
        memAccess = 1'b1; sramReady = 1'b0; branchTaken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mw_freezeAll", int'(freezeAll), 1);
            chk("mw_noflush",   int'(flushIFID), 0);
            tick();
        end
        sramReady = 1'b1;
        #1;
        chk("mw_release",  int'(freezeAll), 0);
        chk("mw_br_flush", int'(flushIFID), 1);
        tick();
        idle();
        #1;
        chk("mw_waitCount",  int'(waitCount), 4);
        chk("mw_flushCount", int'(flushCount), 1);
        chk("mw_noTimeout",  int'(memTimeout), 0);

        // long wait raises the sticky timeout
        memAccess = 1'b1; sramReady = 1'b0;
        repeat (15) tick();
        chk("to_not_yet", int'(memTimeout), 0);
        tick();
        chk("to_set", int'(memTimeout), 1);
        sramReady = 1'b1;
        tick();
        idle(); countClr = 1'b1;
        tick();
        countClr = 1'b0;
        #1;
        chk("to_sticky_clr", int'(memTimeout), 1);
        chk("to_wait_clr",   int'(waitCount), 0);

        // saturation of the 4-bit counters
        forwardEn = 1'b0; exeWriteBackEn = 1'b1; exeDestination = 4'd2; idSrc1 = 4'd2;
        repeat (20) tick();
        idle();
        #1;
        chk("sat_stall4",  int'(stallCount4), 15);
        chk("sat_stall16", int'(stallCount), 20);

        // reset while in MEM_WAIT
        memAccess = 1'b1; sramReady = 1'b0;
        repeat (3) tick();
        chk("pre_rst_state", int'(u_dut.state_q), int'(MEM_WAIT));
        #1 rst = 1'b0;
        #1;
        chk("rst_state_run",  int'(u_dut.state_q), int'(RUN));
        chk("rst_waitCount",  int'(waitCount), 0);
        chk("rst_stall_zero", int'(stallCount), 0);
        chk("rst_timeout",    int'(memTimeout), 0);
        rst = 1'b1;
        repeat (10) tick();
        sramReady = 1'b1;
        tick();
        idle();
        #1;
        chk("post_rst_wait",    int'(waitCount), 10);
        chk("post_rst_timeout", int'(memTimeout), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline control block that drives the flush and freeze inputs of the ID→EXE pipeline register and the other inter-stage registers. It consumes that register's outputs (destination, writeBackEn, memRead, src1, src2) together with ID- and MEM/WB-stage fields. From these it detects data hazards, inserts bubbles, squashes wrong-path instructions on taken branches, freezes the whole pipeline during multi-cycle SRAM accesses, and selects EXE operand forwarding. It also keeps saturating stall/flush statistics.

## Interface
- CW, default 16: width of each statistics counter.
- MAX_WAIT, default 15: number of MEM_WAIT cycles after which memTimeout is raised.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset, asynchronous and active-low (asserted when 0).
- forwardEn  input  1  enables forwarding; when 0, all register-dependence hazards stall.
- idSrc1, idSrc2  input  4  source registers of the instruction in ID.
- idTwoSrc  input  1  the ID instruction reads idSrc2.
- exeDestination  input  4  destination of the EXE instruction (ID→EXE register output).
- exeWriteBackEn  input  1  the EXE instruction writes back.
- exeMemRead  input  1  the EXE instruction is a load.
- exeSrc1, exeSrc2  input  4  sources of the EXE instruction.
- memDestination  input  4  destination of the MEM instruction.
- memWriteBackEn  input  1  the MEM instruction writes back.
- memAccess  input  1  the MEM instruction reads or writes SRAM this cycle.
- wbDestination  input  4  destination of the WB instruction.
- wbWriteBackEn  input  1  the WB instruction writes back.
- branchTaken  input  1  the EXE instruction redirects the PC.
- sramReady  input  1  the SRAM controller completes the current access.
- countClr  input  1  synchronous clear of the statistics counters.
- freezeFront  output  1  holds the PC and the IF/ID register.
- flushIFID  output  1  zeroes the IF/ID register.
- flushID2EXE  output  1  zeroes the ID→EXE register (bubble).
- freezeAll  output  1  holds every pipeline register and the PC.
- sel1, sel2  output  2  EXE operand source: 00 register file, 01 MEM result, 10 WB result.
- memTimeout  output  1  sticky flag: a memory wait exceeded MAX_WAIT cycles.
- stallCount, flushCount, waitCount  output  CW  statistics counters.

## Operation
- The FSM has two states, RUN and MEM_WAIT. Reset state is RUN.
- Transitions:
  - RUN→MEM_WAIT when memAccess=1 and sramReady=0.
  - MEM_WAIT→RUN on the cycle sramReady=1.
- freezeAll = memAccess & ~sramReady, evaluated combinationally in either state. This gives zero-latency freeze; the FSM exists only to count wait cycles.
- Hazard term, hz:
  - Match on exe: exeWriteBackEn & exeDestination==idSrc1, or ==idSrc2 when idTwoSrc.
  - Match on mem: the same compare using memWriteBackEn and memDestination.
  - When forwardEn=0: hz = exe match | mem match.
  - When forwardEn=1: hz = exeMemRead & exe match (load-use only).
- Output priority, highest first:
  1. freezeAll=1: freezeFront=1, flushIFID=0, flushID2EXE=0.
  2. branchTaken=1: flushIFID=1, flushID2EXE=1, freezeFront=0. The hazard is ignored because the ID instruction is squashed.
  3. hz=1: freezeFront=1, flushID2EXE=1.
  4. Otherwise, all control outputs are 0.
- Forwarding for sel1, evaluated against exeSrc1:
  - 01 if forwardEn & memWriteBackEn & memDestination==exeSrc1.
  - Else 10 if forwardEn & wbWriteBackEn & wbDestination==exeSrc1.
  - Else 00.
  - MEM has priority over WB. sel2 uses the same rule on exeSrc2. Both are 00 when forwardEn=0.
- Counters saturate at 2^CW−1 and never wrap:
  - stallCount increments on each cycle where priority case 3 applies.
  - flushCount increments on each cycle where case 2 applies.
  - waitCount increments on each cycle with freezeAll=1.
- countClr zeroes all three counters. countClr wins over a simultaneous increment.
- An internal wait counter (width clog2(MAX_WAIT+1)+1) resets to 0 on entry to MEM_WAIT and increments each MEM_WAIT cycle. memTimeout sets when it reaches MAX_WAIT, stays set until reset, and is not cleared by countClr.

## Timing
- freezeFront, flushIFID, flushID2EXE, freezeAll, sel1 and sel2 are combinational, with 0-cycle latency.
- Counters, FSM state and memTimeout are registered; each reflects an event on the clock edge that follows it.
- Reset values: state RUN, all counters 0, memTimeout 0. Combinational outputs follow their inputs during reset.
- Reset asserted in MEM_WAIT returns the FSM to RUN immediately.
- A load-use hazard produces exactly one bubble: in the next cycle the load has left EXE and forwarding from MEM covers the dependency.
- A branch taken during freezeAll is not flushed until the first unfrozen cycle, because EXE is held.

## Structure
- A shared package holds the sel encodings (FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10) and the FSM state constants.
- One sub-module, sat_counter (parameter CW; inputs inc and clr), is instantiated three times.

## Test plan
- Load-use stall: forwardEn=1, exeMemRead=1, exeDestination=3, idSrc1=3 → freezeFront=1 and flushID2EXE=1 for one cycle; stallCount goes 0→1.
- No-forwarding stall: forwardEn=0, memWriteBackEn=1, memDestination=5, idTwoSrc=1, idSrc2=5 → stall. With idTwoSrc=0 → no stall.
- Branch over hazard: branchTaken=1 together with a load-use hazard → flushIFID=1, flushID2EXE=1, freezeFront=0; flushCount +1, stallCount unchanged.
- Forward priority: memDestination=wbDestination=exeSrc1=7, both writeBackEn=1 → sel1=01. With memWriteBackEn=0 → sel1=10.
- Memory wait: memAccess=1 with sramReady low for 4 cycles → freezeAll high for exactly 4 cycles; waitCount=4, memTimeout=0. Hold sramReady low for 16 cycles → memTimeout=1, and it stays 1 after countClr.
- Saturation and reset: CW=4, 20 hazard cycles → stallCount=15. Drop rst in MEM_WAIT → state RUN and all counters 0 immediately.
